// File: rtl/bram_stream_reader_if.sv
// BRAM port plus valid/ready/last stream bundle used by bram_stream_reader.
// master = the reader side, slave = the BRAM model / stream consumer side.
interface bram_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  ram_en;
    logic                  ram_wen;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output ram_en, ram_wen, ram_addr, ram_din,
        input  ram_dout,
        output m_valid, m_data, m_last,
        input  m_ready
    );

    modport slave (
        input  ram_en, ram_wen, ram_addr, ram_din,
        output ram_dout,
        input  m_valid, m_data, m_last,
        output m_ready
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Streams a contiguous BRAM address range out as valid/ready/last words via a 2-entry buffer.
// Optional abort/aborted ports are enabled by defining BRAM_STREAM_READER_ABORT_EN.
module bram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
`ifdef BRAM_STREAM_READER_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    bram_stream_reader_if.master  bus
);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      issued_q;
    logic [CNT_W-1:0]      pushed_q;
    logic [1:0]            count_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] slot0_q, slot1_q;
    logic                  last0_q, last1_q;
    logic                  busy_q, done_q;
`ifdef BRAM_STREAM_READER_ABORT_EN
    logic                  aborted_q;
`endif

    logic       issue, finish, accept, zero_len, kill;
    logic       pop, push, push_last;
    logic [2:0] occ;

    assign pop       = (count_q != 2'd0) && bus.m_ready;
    assign push      = inflight_q;
    assign push_last = (pushed_q + CNT_W'(1)) == len_q;
    // Projected occupancy once the in-flight word lands and this cycle's pop leaves.
    assign occ       = 3'(count_q) + 3'(inflight_q) - 3'(pop);

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        finish   = 1'b0;
        accept   = 1'b0;
        zero_len = 1'b0;
        kill     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        zero_len = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if ((occ < 3'd2) && (issued_q != len_q)) begin
                    issue = 1'b1;
                    if ((issued_q + CNT_W'(1)) == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && pop && last0_q) begin
            finish  = 1'b1;
            state_d = IDLE;
        end
`ifdef BRAM_STREAM_READER_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            kill    = 1'b1;
            issue   = 1'b0;
            finish  = 1'b0;
            state_d = IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            pushed_q   <= '0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            last0_q    <= 1'b0;
            last1_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef BRAM_STREAM_READER_ABORT_EN
            aborted_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != IDLE);
            done_q     <= finish | zero_len | kill;
`ifdef BRAM_STREAM_READER_ABORT_EN
            aborted_q  <= kill;
`endif
            inflight_q <= issue;
            if (accept) begin
                base_q   <= base_addr;
                len_q    <= length;
                issued_q <= '0;
                pushed_q <= '0;
            end
            if (issue) begin
                issued_q <= issued_q + CNT_W'(1);
            end
            if (kill) begin
                count_q <= 2'd0;
                last0_q <= 1'b0;
                last1_q <= 1'b0;
            end else begin
                if (push) begin
                    pushed_q <= pushed_q + CNT_W'(1);
                end
                // Head slot drives the stream directly; slot1 only fills behind a stalled head.
                case ({push, pop})
                    2'b10: begin
                        if (count_q == 2'd0) begin
                            slot0_q <= bus.ram_dout;
                            last0_q <= push_last;
                        end else begin
                            slot1_q <= bus.ram_dout;
                            last1_q <= push_last;
                        end
                        count_q <= count_q + 2'd1;
                    end
                    2'b01: begin
                        if (count_q == 2'd2) begin
                            slot0_q <= slot1_q;
                            last0_q <= last1_q;
                        end else begin
                            last0_q <= 1'b0;
                        end
                        last1_q <= 1'b0;
                        count_q <= count_q - 2'd1;
                    end
                    2'b11: begin
                        slot0_q <= bus.ram_dout;
                        last0_q <= push_last;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.ram_en   = issue;
    assign bus.ram_wen  = 1'b0;
    assign bus.ram_addr = base_q + issued_q[ADDR_WIDTH-1:0];
    assign bus.ram_din  = '0;
    assign bus.m_valid  = (count_q != 2'd0);
    assign bus.m_data   = slot0_q;
    assign bus.m_last   = last0_q;
    assign busy         = busy_q;
    assign done         = done_q;
`ifdef BRAM_STREAM_READER_ABORT_EN
    assign aborted      = aborted_q;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed self-checking bench for bram_stream_reader against a read-first BRAM model.
`timescale 1ns/1ps
module tb_bram_stream_reader;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done;
`ifdef BRAM_STREAM_READER_ABORT_EN
    logic          abort = 1'b0;
    logic          aborted;
`endif

    bram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
`ifdef BRAM_STREAM_READER_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (bus.ram_en) bus.ram_dout <= mem[bus.ram_addr];

    int vecs = 0;
    int errs = 0;

    logic          r_en [0:63];
    logic [AW-1:0] r_addr [0:63];
    logic          r_v [0:63];
    logic [DW-1:0] r_d [0:63];
    logic          r_l [0:63];
    logic          r_dn [0:63];
    logic          r_bs [0:63];
    logic          r_rdy [0:63];
    logic          r_ab [0:63];
    logic [DW-1:0] hs_d [$];
    logic          hs_l [$];
    logic          wd_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One directed transfer: start held st_n cycles, optional reset/abort at a given cycle.
    task automatic run(input int n, input logic [AW-1:0] b, input logic [AW:0] len, input int st_n,
                       input int rdy_mode, input int rst_k, input int abort_k);
        hs_d.delete();
        hs_l.delete();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start = (k < st_n);
            base_addr = (k == 0) ? b : 10'h155;
            length = (k == 0) ? len : 11'd7;
            bus.m_ready = (rdy_mode == 0) ? 1'b1 : ((k % 6 == 0) || (k % 6 == 3) || (k % 6 == 5));
            rst_n = (k != rst_k);
`ifdef BRAM_STREAM_READER_ABORT_EN
            abort = (k == abort_k);
`endif
            #1;
            r_en[k] = bus.ram_en;
            r_addr[k] = bus.ram_addr;
            r_v[k] = bus.m_valid;
            r_d[k] = bus.m_data;
            r_l[k] = bus.m_last;
            r_dn[k] = done;
            r_bs[k] = busy;
            r_rdy[k] = bus.m_ready;
`ifdef BRAM_STREAM_READER_ABORT_EN
            r_ab[k] = aborted;
`else
            r_ab[k] = 1'b0;
`endif
            wd_seen = wd_seen | bus.ram_wen | (|bus.ram_din);
            if (bus.m_valid && bus.m_ready) begin
                hs_d.push_back(bus.m_data);
                hs_l.push_back(bus.m_last);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
`ifdef BRAM_STREAM_READER_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    // Expected timeline for an unstalled transfer started in cycle 0.
    task automatic chk_burst(input string t, input logic [AW-1:0] b, input int len);
        logic [AW-1:0] a;
        for (int k = 1; k <= len; k++) begin
            a = b + AW'(k - 1);
            chk($sformatf("%s en k%0d", t, k), 32'(r_en[k]), 32'd1);
            chk($sformatf("%s addr k%0d", t, k), 32'(r_addr[k]), 32'(a));
        end
        chk($sformatf("%s en_after", t), 32'(r_en[len+1]), 32'd0);
        chk($sformatf("%s busy k1", t), 32'(r_bs[1]), 32'd1);
        chk($sformatf("%s valid k2", t), 32'(r_v[2]), 32'd0);
        for (int j = 0; j < len; j++) begin
            a = b + AW'(j);
            chk($sformatf("%s valid k%0d", t, j + 3), 32'(r_v[j+3]), 32'd1);
            chk($sformatf("%s data k%0d", t, j + 3), 32'(r_d[j+3]), 32'(a[DW-1:0]));
            chk($sformatf("%s last k%0d", t, j + 3), 32'(r_l[j+3]), 32'(j == len - 1));
        end
        chk($sformatf("%s done_early", t), 32'(r_dn[len+2]), 32'd0);
        chk($sformatf("%s done", t), 32'(r_dn[len+3]), 32'd1);
        chk($sformatf("%s busy_end", t), 32'(r_bs[len+3]), 32'd0);
        chk($sformatf("%s valid_end", t), 32'(r_v[len+3]), 32'd0);
    endtask

    function automatic int done_count(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(r_dn[k]);
        return c;
    endfunction

    logic [AW-1:0] t2a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [DW-1:0] t2d [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    initial begin
        int cnt;
        int infl;
        int pop;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        bus.m_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst ram_en", 32'(bus.ram_en), 32'd0);
        chk("rst ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst m_last", 32'(bus.m_last), 32'd0);
        chk("rst m_data", 32'(bus.m_data), 32'd0);
        chk("rst ram_wen", 32'(bus.ram_wen), 32'd0);

        // Basic 4-word burst at 0x010
        run(10, 10'h010, 11'd4, 1, 0, -1, -1);
        chk_burst("t1", 10'h010, 4);
        chk("t1 ndone", 32'(done_count(10)), 32'd1);

        // Address wrap at top of memory
        run(10, 10'h3FE, 11'd4, 1, 0, -1, -1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t2 en k%0d", k), 32'(r_en[k]), 32'd1);
            chk($sformatf("t2 addr k%0d", k), 32'(r_addr[k]), 32'(t2a[k-1]));
            chk($sformatf("t2 data k%0d", k + 2), 32'(r_d[k+2]), 32'(t2d[k-1]));
        end
        chk("t2 last", 32'(r_l[6]), 32'd1);
        chk("t2 done", 32'(r_dn[7]), 32'd1);

        // Backpressure: 8 words with m_ready toggling
        run(40, 10'h010, 11'd8, 1, 1, -1, -1);
        chk("t3 nhs", 32'(hs_d.size()), 32'd8);
        for (int i = 0; i < hs_d.size() && i < 8; i++) begin
            chk($sformatf("t3 hs%0d data", i), 32'(hs_d[i]), 32'(8'h10 + 8'(i)));
            chk($sformatf("t3 hs%0d last", i), 32'(hs_l[i]), 32'(i == 7));
        end
        chk("t3 ndone", 32'(done_count(40)), 32'd1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            pop = int'(r_v[k] & r_rdy[k]);
            infl = (k > 0) ? int'(r_en[k-1]) : 0;
            if (r_en[k]) chk($sformatf("t3 room k%0d", k), 32'(cnt + infl - pop < 2), 32'd1);
            chk($sformatf("t3 valid k%0d", k), 32'(r_v[k]), 32'(cnt != 0));
            if (k < 39 && r_v[k] && !r_rdy[k]) begin
                chk($sformatf("t3 hold_v k%0d", k), 32'(r_v[k+1]), 32'd1);
                chk($sformatf("t3 hold_d k%0d", k), 32'(r_d[k+1]), 32'(r_d[k]));
                chk($sformatf("t3 hold_l k%0d", k), 32'(r_l[k+1]), 32'(r_l[k]));
            end
            cnt = cnt + infl - pop;
        end

        // Zero length: no access, busy stays low, single done
        run(6, 10'h200, 11'd0, 1, 0, -1, -1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t4 en k%0d", k), 32'(r_en[k]), 32'd0);
            chk($sformatf("t4 busy k%0d", k), 32'(r_bs[k]), 32'd0);
        end
        chk("t4 done k1", 32'(r_dn[1]), 32'd1);
        chk("t4 ndone", 32'(done_count(6)), 32'd1);

        // Start held high through the transfer: no restart, no re-capture
        run(12, 10'h020, 11'd4, 7, 0, -1, -1);
        chk_burst("t4b", 10'h020, 4);
        for (int k = 8; k < 12; k++) chk($sformatf("t4b idle_en k%0d", k), 32'(r_en[k]), 32'd0);
        chk("t4b ndone", 32'(done_count(12)), 32'd1);

        // Reset after the 2nd handshake of a 6-word transfer
        run(10, 10'h030, 11'd6, 1, 0, 5, -1);
        chk("t5 hs2 data", 32'(r_d[4]), 32'h31);
        chk("t5 valid", 32'(r_v[6]), 32'd0);
        chk("t5 busy", 32'(r_bs[6]), 32'd0);
        chk("t5 en", 32'(r_en[6]), 32'd0);
        chk("t5 ndone", 32'(done_count(10)), 32'd0);
        run(8, 10'h050, 11'd2, 1, 0, -1, -1);
        chk_burst("t5b", 10'h050, 2);

`ifdef BRAM_STREAM_READER_ABORT_EN
        // Abort after the 3rd handshake of a 10-word transfer
        run(16, 10'h010, 11'd10, 1, 0, -1, 6);
        chk("t6 hs3 data", 32'(r_d[5]), 32'h12);
        chk("t6 en_abort", 32'(r_en[6]), 32'd0);
        for (int k = 7; k < 16; k++) begin
            chk($sformatf("t6 valid k%0d", k), 32'(r_v[k]), 32'd0);
            chk($sformatf("t6 en k%0d", k), 32'(r_en[k]), 32'd0);
        end
        chk("t6 done", 32'(r_dn[7]), 32'd1);
        chk("t6 aborted", 32'(r_ab[7]), 32'd1);
        chk("t6 busy", 32'(r_bs[7]), 32'd0);
        chk("t6 done_off", 32'(r_dn[8]), 32'd0);
        chk("t6 aborted_off", 32'(r_ab[8]), 32'd0);
        run(8, 10'h060, 11'd2, 1, 0, -1, -1);
        chk_burst("t6b", 10'h060, 2);
        chk("t6b aborted", 32'(r_ab[5]), 32'd0);
`endif

        chk("wen/din zero", 32'(wd_seen), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
Read-side initiator for one port of the team's true-dual-port, read-first BRAM. It drives the BRAM port signals (1-cycle read latency) to fetch a contiguous address range. It presents the words as a valid/ready stream with a last marker and absorbs downstream backpressure in a 2-entry buffer without dropping or duplicating words. It sits between a BRAM port and stream consumers such as a UART TX or DMA.

Parameters:
DATA_WIDTH, 8, word width; matches the BRAM DATA_WIDTH.
ADDR_WIDTH, 10, BRAM address width; depth is 2**ADDR_WIDTH.

Ports:
clk  in  1  single clock; all logic on posedge.
rst_n  in  1  synchronous active-low reset.
start  in  1  launch a transfer; sampled only in IDLE.
base_addr  in  ADDR_WIDTH  first address; captured when start is accepted.
length  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH; captured when start is accepted.
busy  out  1  transfer in progress.
done  out  1  1-cycle completion pulse.
ram_en  out  1  BRAM port enable.
ram_wen  out  1  BRAM write enable; constant 0.
ram_addr  out  ADDR_WIDTH  BRAM address.
ram_din  out  DATA_WIDTH  BRAM write data; constant 0.
ram_dout  in  DATA_WIDTH  BRAM read data; valid the cycle after ram_en=1.
m_valid  out  1  stream data valid.
m_ready  in  1  consumer ready.
m_data  out  DATA_WIDTH  stream word.
m_last  out  1  high with the final word of a transfer.

Behaviour:
- Reset: while rst_n=0 at a posedge, everything clears on that edge. State=IDLE; busy, done, ram_en, m_valid and m_last = 0; ram_addr and m_data = 0; buffer is flushed; any in-flight read is discarded. Reset mid-transfer aborts silently with no done pulse.
- FSM states: IDLE, READ, DRAIN.
- IDLE, start=1, length>0: capture base_addr and length, issue counter=0, beat counter=0, go to READ. busy=1 from the next cycle.
- IDLE, start=1, length=0: no BRAM access. done=1 for one cycle on the next cycle; busy stays 0.
- start in READ or DRAIN is ignored, and base_addr/length are not re-sampled.
- Issue rule (READ): ram_en=1 with ram_addr=(base+issued) mod 2**ADDR_WIDTH when (count + inflight - pop) < 2.
  - count = buffer occupancy (0..2); inflight = ram_en of the previous cycle; pop = m_valid & m_ready.
  - This sustains 1 word/clk when m_ready stays high.
  - ram_en=0 on all other cycles.
  - Address wraps from 2**ADDR_WIDTH-1 to 0.
- Capture: if ram_en was 1 in cycle c, ram_dout is pushed into the buffer at the end of cycle c+1.
  - The first m_valid appears in cycle c+2.
  - Start-to-first-m_valid is 3 clocks.
- Once issued==length, go to DRAIN. No further ram_en.
- Stream rules:
  - m_valid = (count != 0); m_data = buffer head.
  - While m_valid & !m_ready, m_data and m_last stay stable.
  - Words leave in address order.
  - m_last=1 exactly when the head is beat length-1.
  - A simultaneous push and pop at count=2 cannot occur (guaranteed by the issue rule); a push and pop at count=1 keep count=1.
- Completion: the handshake with m_last=1 moves the FSM to IDLE. done=1 and busy=0 in the following cycle. A new start is accepted in that same done cycle.
- length=2**ADDR_WIDTH reads the whole memory once, starting and ending at base_addr wrap-around.

Optional Feature:
Macro BRAM_STREAM_READER_ABORT_EN.
- Defined: adds input abort (1) and output aborted (1).
- abort=1 in READ or DRAIN:
  - stops issuing immediately (ram_en=0 that cycle);
  - discards the in-flight word and flushes the buffer; m_valid=0 the next cycle;
  - goes to IDLE; done=1 and aborted=1 for one cycle the next cycle.
- abort in IDLE has no effect.
- abort has priority over a same-cycle handshake; that word counts as delivered.
- Undefined: the ports do not exist, and behaviour is exactly as above.

Test Plan:
- Memory preloaded mem[i]=i[7:0]; start with base=0x010, length=4, m_ready=1 → ram_en for 4 consecutive cycles at 0x010..0x013. m_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles, first one 3 clocks after start. m_last on 0x13; done pulse the next cycle.
- base=0x3FE, length=4 → addresses 0x3FE,0x3FF,0x000,0x001 and data 0xFE,0xFF,0x00,0x01.
- length=8 with m_ready toggling 1,0,0,1,0,1... → exactly 8 handshakes with data 0x10..0x17 in order, no repeats. m_data stable while stalled; ram_en never issues when count+inflight-pop=2.
- length=0 → no ram_en, busy stays 0, done pulses once 1 cycle after start. Also: start held high during a length=4 transfer → no restart and no re-capture.
- rst_n=0 for 1 cycle after the 2nd handshake of a length=6 transfer → next cycle m_valid=0, busy=0, ram_en=0, no done. A new start then runs normally from its base.
- With BRAM_STREAM_READER_ABORT_EN: abort after 3rd handshake of length=10, m_ready=1 → no further m_valid. done=1 and aborted=1 exactly one cycle later; the next start works normally.
